// File: rtl/fsm_slave_regs.sv
// I2C slave exposing NUM_REGS byte registers, with a combinational local read port.
// Optional FSM_SLAVE_AUTOINC_EN: pointer advances after every data byte written or read.
`timescale 1ns/1ps
module fsm_slave_regs #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned PTR_W      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             scl_in,
    input  logic             sda_in,
    input  logic             fsm_select_,
    output logic             sda_select,
    output logic             sda_out,
    input  logic [PTR_W-1:0] loc_addr,
    output logic [7:0]       loc_data,
    output logic             wr_pulse,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);

`ifdef FSM_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_p, sda_p;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic [7:0]       shift_q, shift_d, rx_byte;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rw_q, rw_d;
    logic             sda_sel_q, sda_sel_d, sda_out_q, sda_out_d;
    logic             busy_q, busy_d;
    logic             wr_pulse_q, wr_pulse_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_p    <= scl_s;
            sda_p    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        phase_d    = phase_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_sel_d  = sda_sel_q;
        sda_out_d  = sda_out_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rx_byte    = {shift_q[6:0], sda_s};

        if (fsm_select_ || stop_det) begin
            state_d   = IDLE;
            sda_sel_d = 1'b0;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            phase_d   = '0;
            sda_sel_d = 1'b0;
            sda_out_d = 1'b1;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                IDLE, IGNORE: ;
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        phase_d   = '0;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    rw_d    = rx_byte[0];
                                    state_d = ADDR_ACK;
                                end else begin
                                    state_d = IGNORE;
                                end
                            end else if (state_q == PTR) begin
                                ptr_d   = rx_byte[PTR_W-1:0];
                                state_d = PTR_ACK;
                            end else begin
                                wr_pulse_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = rx_byte;
                                ptr_d      = AUTOINC ? ptr_q + 1'b1 : ptr_q;
                                state_d    = WDATA_ACK;
                            end
                        end
                    end
                end
                // Phase 0: drive the ACK low on the fall after bit 8; phase 1: leave on the next fall.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (phase_q == 2'd0) begin
                            sda_sel_d = 1'b1;
                            sda_out_d = 1'b0;
                            phase_d   = 2'd1;
                        end else begin
                            sda_sel_d = 1'b0;
                            sda_out_d = 1'b1;
                            bit_cnt_d = '0;
                            phase_d   = 2'd0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                state_d   = RDATA;
                                shift_d   = regs[ptr_q];
                                sda_sel_d = 1'b1;
                                sda_out_d = regs[ptr_q][7];
                            end else if (state_q == ADDR_ACK) begin
                                state_d = PTR;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        sda_out_d = shift_q[6];
                        shift_d   = {shift_q[6:0], 1'b0};
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = RDATA_ACK;
                            phase_d = 2'd0;
                        end
                    end
                end
                // Phase 0: release after bit 8; phase 1: sample master ACK; phase 2: reload on fall.
                RDATA_ACK: begin
                    if (phase_q == 2'd0 && scl_fall) begin
                        sda_sel_d = 1'b0;
                        sda_out_d = 1'b1;
                        phase_d   = 2'd1;
                    end else if (phase_q == 2'd1 && scl_rise) begin
                        ptr_d = AUTOINC ? ptr_q + 1'b1 : ptr_q;
                        if (sda_s) state_d = IGNORE;
                        else       phase_d = 2'd2;
                    end else if (phase_q == 2'd2 && scl_fall) begin
                        state_d   = RDATA;
                        bit_cnt_d = '0;
                        phase_d   = 2'd0;
                        shift_d   = regs[ptr_q];
                        sda_sel_d = 1'b1;
                        sda_out_d = regs[ptr_q][7];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            phase_q    <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_sel_q  <= 1'b0;
            sda_out_q  <= 1'b1;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_sel_q  <= sda_sel_d;
            sda_out_q  <= sda_out_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Register file commits the cycle after the strobe, so loc_data follows wr_pulse by one clk.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_pulse_q) begin
            regs[wr_addr_q] <= wr_data_q;
        end
    end

    assign loc_data   = regs[loc_addr];
    assign sda_select = sda_sel_q & ~fsm_select_;
    assign sda_out    = sda_out_q;
    assign busy       = busy_q;
    assign wr_pulse   = wr_pulse_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_fsm_slave_regs.sv
// Directed bench for fsm_slave_regs: bit-banged I2C master on a wired-AND SDA line.
`timescale 1ns/1ps
module tb_fsm_slave_regs;
    localparam int Q = 8;
`ifdef FSM_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk, rst_, m_scl, m_sda, fsm_select_;
    logic       sda_select, sda_out, wr_pulse, busy, sda_bus;
    logic [3:0] loc_addr, wr_addr;
    logic [7:0] loc_data, wr_data;

    int n_cmp = 0;
    int n_fail = 0;
    int sel_cnt = 0;
    int long_cnt = 0;
    logic wr_prev;
    logic [3:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];

    // Expected register contents after test_write, in either pointer mode
    localparam logic [7:0] EXP_R3 = AUTOINC ? 8'h5A : 8'hC3;
    localparam logic [7:0] EXP_R4 = AUTOINC ? 8'hC3 : 8'h00;

    fsm_slave_regs #(.SLAVE_ADDR(7'h50), .NUM_REGS(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_(rst_), .scl_in(m_scl), .sda_in(sda_bus),
        .fsm_select_(fsm_select_), .sda_select(sda_select), .sda_out(sda_out),
        .loc_addr(loc_addr), .loc_data(loc_data), .wr_pulse(wr_pulse),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    assign sda_bus = m_sda & ~(sda_select & ~sda_out);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_pulse) begin
            wr_addr_log.push_back(wr_addr);
            wr_data_log.push_back(wr_data);
            if (wr_prev === 1'b1) long_cnt++;
        end
        if (sda_select === 1'b1) sel_cnt++;
        wr_prev = wr_pulse;
    end

    task automatic wait_q();
        repeat (Q) @(posedge clk);
    endtask
    task automatic i2c_start();
        m_sda = 1'b1; wait_q(); m_scl = 1'b1; wait_q(); m_sda = 1'b0; wait_q(); m_scl = 1'b0; wait_q();
    endtask
    task automatic i2c_stop();
        m_sda = 1'b0; wait_q(); m_scl = 1'b1; wait_q(); m_sda = 1'b1; wait_q(); wait_q();
    endtask
    task automatic put_bit(input logic b);
        m_sda = b; wait_q(); m_scl = 1'b1; wait_q(); wait_q(); m_scl = 1'b0; wait_q();
    endtask
    task automatic get_bit(output logic b);
        m_sda = 1'b1; wait_q(); m_scl = 1'b1; wait_q(); @(negedge clk); b = sda_bus; wait_q(); m_scl = 1'b0; wait_q();
    endtask
    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask
    task automatic get_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin get_bit(b); d[i] = b; end
        put_bit(nack);
    endtask

    task automatic test_reset();
        rst_ = 1'b0; fsm_select_ = 1'b0; m_scl = 1'b1; m_sda = 1'b1; loc_addr = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (sda_select !== 1'b0) begin n_fail++; $display("FAIL reset_sda_select: got %b want 0", sda_select); end
        n_cmp++; if (sda_out !== 1'b1) begin n_fail++; $display("FAIL reset_sda_out: got %b want 1", sda_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({wr_pulse, wr_addr, wr_data} !== 13'd0) begin n_fail++; $display("FAIL reset_wr: got %b/%h/%h want 0/0/00", wr_pulse, wr_addr, wr_data); end
        loc_addr = 4'd15; #1;
        n_cmp++; if (loc_data !== 8'h00) begin n_fail++; $display("FAIL reset_reg15: got %h want 00", loc_data); end
        rst_ = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_no_autoinc();
        logic ack; int base;
        base = wr_addr_log.size();
        i2c_start();
        put_byte(8'hA0, ack);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL noinc_addr_ack: got %b want 0", ack); end
        put_byte(8'h02, ack);
        put_byte(8'h77, ack);
        put_byte(8'h88, ack);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL noinc_data_ack: got %b want 0", ack); end
        i2c_stop();
        n_cmp++; if (wr_addr_log.size() !== base + 2) begin n_fail++; $display("FAIL noinc_wr_count: got %0d want %0d", wr_addr_log.size() - base, 2); end
        n_cmp++; if (wr_addr_log[base+1] !== (AUTOINC ? 4'd3 : 4'd2)) begin n_fail++; $display("FAIL noinc_wr_addr2: got %h want %h", wr_addr_log[base+1], AUTOINC ? 4'd3 : 4'd2); end
        loc_addr = 4'd2; #1;
        n_cmp++; if (loc_data !== (AUTOINC ? 8'h77 : 8'h88)) begin n_fail++; $display("FAIL noinc_reg2: got %h want %h", loc_data, AUTOINC ? 8'h77 : 8'h88); end
        loc_addr = 4'd3; #1;
        n_cmp++; if (loc_data !== (AUTOINC ? 8'h88 : 8'h00)) begin n_fail++; $display("FAIL noinc_reg3: got %h want %h", loc_data, AUTOINC ? 8'h88 : 8'h00); end
    endtask

    task automatic test_write();
        logic [3:0] acks; logic ack; int base;
        base = wr_addr_log.size();
        i2c_start();
        put_byte(8'hA0, ack); acks[3] = ack;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b want 1", busy); end
        put_byte(8'h03, ack); acks[2] = ack;
        put_byte(8'h5A, ack); acks[1] = ack;
        put_byte(8'hC3, ack); acks[0] = ack;
        i2c_stop();
        n_cmp++; if (acks !== 4'b0000) begin n_fail++; $display("FAIL write_acks: got %b want 0000", acks); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_stop: got %b want 0", busy); end
        n_cmp++; if (wr_addr_log.size() !== base + 2) begin n_fail++; $display("FAIL write_wr_count: got %0d want 2", wr_addr_log.size() - base); end
        n_cmp++; if ({wr_addr_log[base], wr_data_log[base]} !== {4'd3, 8'h5A}) begin n_fail++; $display("FAIL write_pulse1: got %h/%h want 3/5a", wr_addr_log[base], wr_data_log[base]); end
        n_cmp++; if ({wr_addr_log[base+1], wr_data_log[base+1]} !== {(AUTOINC ? 4'd4 : 4'd3), 8'hC3}) begin n_fail++; $display("FAIL write_pulse2: got %h/%h want %h/c3", wr_addr_log[base+1], wr_data_log[base+1], AUTOINC ? 4'd4 : 4'd3); end
        n_cmp++; if (long_cnt !== 0) begin n_fail++; $display("FAIL write_pulse_width: got %0d long pulses want 0", long_cnt); end
        loc_addr = 4'd3; #1;
        n_cmp++; if (loc_data !== EXP_R3) begin n_fail++; $display("FAIL write_reg3: got %h want %h", loc_data, EXP_R3); end
        loc_addr = 4'd4; #1;
        n_cmp++; if (loc_data !== EXP_R4) begin n_fail++; $display("FAIL write_reg4: got %h want %h", loc_data, EXP_R4); end
    endtask

    task automatic test_repeated_start_read();
        logic ack; logic [7:0] d0, d1; int sel0;
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h03, ack);
        i2c_start();
        put_byte(8'hA1, ack);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL read_addr_ack: got %b want 0", ack); end
        get_byte(d0, 1'b0);
        get_byte(d1, 1'b1);
        n_cmp++; if (d0 !== EXP_R3) begin n_fail++; $display("FAIL read_byte0: got %h want %h", d0, EXP_R3); end
        n_cmp++; if (d1 !== (AUTOINC ? EXP_R4 : EXP_R3)) begin n_fail++; $display("FAIL read_byte1: got %h want %h", d1, AUTOINC ? EXP_R4 : EXP_R3); end
        @(negedge clk);
        n_cmp++; if (sda_select !== 1'b0) begin n_fail++; $display("FAIL read_release_nack: got %b want 0", sda_select); end
        sel0 = sel_cnt;
        put_bit(1'b0);
        i2c_stop();
        n_cmp++; if (sel_cnt !== sel0) begin n_fail++; $display("FAIL read_stays_released: got %0d drive cycles want 0", sel_cnt - sel0); end
    endtask

    task automatic test_addr_mismatch();
        logic ack; logic [2:0] acks; int base, sel0;
        base = wr_addr_log.size(); sel0 = sel_cnt;
        i2c_start();
        put_byte(8'hA2, ack); acks[2] = ack;
        put_byte(8'h05, ack); acks[1] = ack;
        put_byte(8'h99, ack); acks[0] = ack;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mismatch_busy: got %b want 1", busy); end
        i2c_stop();
        n_cmp++; if (acks !== 3'b111) begin n_fail++; $display("FAIL mismatch_acks: got %b want 111", acks); end
        n_cmp++; if (sel_cnt !== sel0) begin n_fail++; $display("FAIL mismatch_drive: got %0d drive cycles want 0", sel_cnt - sel0); end
        n_cmp++; if (wr_addr_log.size() !== base) begin n_fail++; $display("FAIL mismatch_wr: got %0d pulses want 0", wr_addr_log.size() - base); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy_stop: got %b want 0", busy); end
    endtask

    task automatic test_wrap();
        logic ack; int base;
        base = wr_addr_log.size();
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h0F, ack);
        put_byte(8'h11, ack);
        put_byte(8'h22, ack);
        i2c_stop();
        n_cmp++; if (wr_addr_log[base+1] !== (AUTOINC ? 4'd0 : 4'd15)) begin n_fail++; $display("FAIL wrap_wr_addr2: got %h want %h", wr_addr_log[base+1], AUTOINC ? 4'd0 : 4'd15); end
        loc_addr = 4'd15; #1;
        n_cmp++; if (loc_data !== (AUTOINC ? 8'h11 : 8'h22)) begin n_fail++; $display("FAIL wrap_reg15: got %h want %h", loc_data, AUTOINC ? 8'h11 : 8'h22); end
        loc_addr = 4'd0; #1;
        n_cmp++; if (loc_data !== (AUTOINC ? 8'h22 : 8'h00)) begin n_fail++; $display("FAIL wrap_reg0: got %h want %h", loc_data, AUTOINC ? 8'h22 : 8'h00); end
    endtask

    task automatic test_fsm_select();
        logic ack; logic [1:0] acks; int base;
        base = wr_addr_log.size();
        i2c_start();
        put_byte(8'hA0, ack);
        @(negedge clk); fsm_select_ = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++; if ({busy, sda_select} !== 2'b00) begin n_fail++; $display("FAIL select_idle: got busy=%b sel=%b want 0/0", busy, sda_select); end
        put_byte(8'h07, ack); acks[1] = ack;
        put_byte(8'h33, ack); acks[0] = ack;
        n_cmp++; if (acks !== 2'b11) begin n_fail++; $display("FAIL select_acks: got %b want 11", acks); end
        n_cmp++; if (wr_addr_log.size() !== base) begin n_fail++; $display("FAIL select_wr: got %0d pulses want 0", wr_addr_log.size() - base); end
        fsm_select_ = 1'b0;
        i2c_stop();
        loc_addr = 4'd3; #1;
        n_cmp++; if (loc_data !== EXP_R3) begin n_fail++; $display("FAIL select_regs_kept: got %h want %h", loc_data, EXP_R3); end
    endtask

    task automatic test_reset_mid_read();
        logic ack, b;
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h03, ack);
        i2c_start();
        put_byte(8'hA1, ack);
        for (int i = 0; i < 3; i++) get_bit(b);
        @(negedge clk);
        n_cmp++; if (sda_select !== 1'b1) begin n_fail++; $display("FAIL midread_driving: got %b want 1", sda_select); end
        rst_ = 1'b0; #1;
        n_cmp++; if ({sda_select, sda_out, busy} !== 3'b010) begin n_fail++; $display("FAIL midread_async_release: got sel=%b out=%b busy=%b want 0/1/0", sda_select, sda_out, busy); end
        loc_addr = 4'd3; #1;
        n_cmp++; if (loc_data !== 8'h00) begin n_fail++; $display("FAIL midread_reg3_cleared: got %h want 00", loc_data); end
        repeat (3) @(posedge clk);
        rst_ = 1'b1;
        repeat (4) @(posedge clk);
        i2c_start();
        put_byte(8'hA0, ack);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL midread_next_ack: got %b want 0", ack); end
        put_byte(8'h01, ack);
        i2c_stop();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_no_autoinc();
        test_write();
        test_repeated_start_read();
        test_addr_mismatch();
        test_wrap();
        test_fsm_select();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
